// File: rtl/ldm_seq_ctrl_if.sv
// ldm_seq_ctrl_if: decode/execute-side signals of the block-transfer sequencer
interface ldm_seq_ctrl_if;
  logic        i_is_ldm;
  logic        i_ldm_p;
  logic        i_ldm_u;
  logic        i_ldm_l;
  logic [15:0] i_ldm_reglist;
  logic        i_flush;
  logic        i_uop_rdy;
  logic        o_stall;
  logic        o_uop_vld;
  logic [3:0]  o_uop_reg;
  logic        o_uop_l;
  logic [7:0]  o_uop_offset;
  logic        o_uop_last;
  logic [7:0]  o_wb_delta;
  logic        o_done;
  modport master (
    output i_is_ldm, i_ldm_p, i_ldm_u, i_ldm_l, i_ldm_reglist, i_flush, i_uop_rdy,
    input  o_stall, o_uop_vld, o_uop_reg, o_uop_l, o_uop_offset, o_uop_last, o_wb_delta, o_done
  );
  modport slave (
    input  i_is_ldm, i_ldm_p, i_ldm_u, i_ldm_l, i_ldm_reglist, i_flush, i_uop_rdy,
    output o_stall, o_uop_vld, o_uop_reg, o_uop_l, o_uop_offset, o_uop_last, o_wb_delta, o_done
  );
endinterface

// File: rtl/ldm_seq_ctrl.sv
// ldm_seq_ctrl: expands one LDM/STM into ascending single-register micro-ops
module ldm_seq_ctrl #(
  parameter int WORD_BYTES = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ldm_seq_ctrl_if.slave bus
);
  typedef enum logic {IDLE, ISSUE} state_e;
  localparam logic [7:0] STEP = 8'(WORD_BYTES);
  state_e      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic        l_q, l_d, done_q, done_d, last;
  logic [7:0]  off_q, off_d, wb_q, wb_d, nb, start;
  logic [4:0]  n;
  logic [3:0]  low;
  always_comb begin
    n = '0;
    for (int k = 0; k < 16; k++) n = n + 5'(bus.i_ldm_reglist[k]);
  end
  assign nb = 8'(n) * STEP;
  // lowest register always sits at the lowest address, so start at the bottom of the block
  assign start = bus.i_ldm_u ? (bus.i_ldm_p ? STEP : 8'd0) : (bus.i_ldm_p ? -nb : STEP - nb);
  always_comb begin
    low = '0;
    for (int k = 15; k >= 0; k--) if (mask_q[k]) low = 4'(k);
  end
  assign last = (state_q == ISSUE) && (mask_q != '0) && ((mask_q & (mask_q - 16'd1)) == '0);
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    l_d     = l_q;
    off_d   = off_q;
    wb_d    = wb_q;
    done_d  = 1'b0;
    if (bus.i_flush) begin
      state_d = IDLE;
      mask_d  = '0;
    end else if (state_q == IDLE && bus.i_is_ldm) begin
      mask_d  = bus.i_ldm_reglist;
      l_d     = bus.i_ldm_l;
      off_d   = start;
      wb_d    = (n == '0) ? 8'd0 : (bus.i_ldm_u ? nb : -nb);
      state_d = (n == '0) ? IDLE : ISSUE;
      done_d  = (n == '0);
    end else if (state_q == ISSUE && bus.i_uop_rdy) begin
      mask_d  = mask_q & (mask_q - 16'd1);
      off_d   = off_q + STEP;
      state_d = last ? IDLE : ISSUE;
      done_d  = last;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      l_q     <= 1'b0;
      off_q   <= '0;
      wb_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      l_q     <= l_d;
      off_q   <= off_d;
      wb_q    <= wb_d;
      done_q  <= done_d;
    end
  end
  assign bus.o_stall      = (state_q == IDLE) ? (bus.i_is_ldm & i_rst_n) : !(bus.i_uop_rdy & last);
  assign bus.o_uop_vld    = (state_q == ISSUE);
  assign bus.o_uop_reg    = low;
  assign bus.o_uop_l      = l_q;
  assign bus.o_uop_offset = off_q;
  assign bus.o_uop_last   = last;
  assign bus.o_wb_delta   = wb_q;
  assign bus.o_done       = done_q;
endmodule

// File: doc/ldm_seq_ctrl.md
Name: ldm_seq_ctrl

Overview:
- Block-transfer sequencer directly downstream of the decode stage.
- Consumes the decoded LDM/STM fields (is_ldm, P, U, L, register list) and expands one block-transfer instruction into a stream of single-register memory micro-ops for the execute stage.
- Stalls fetch/decode until the last micro-op is accepted.
- Also reports the base-register writeback delta.

Parameters:
- WORD_BYTES, 4, byte step between consecutive transfer addresses.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_is_ldm  in  1  decode says a cond-passed block transfer is presented.
- i_ldm_p  in  1  P bit: 1 = before, 0 = after.
- i_ldm_u  in  1  U bit: 1 = increment, 0 = decrement.
- i_ldm_l  in  1  L bit: 1 = load, 0 = store.
- i_ldm_reglist  in  16  register list; bit k = Rk.
- i_flush  in  1  pipeline flush from execute (branch taken).
- i_uop_rdy  in  1  execute stage accepts current micro-op.
- o_stall  out  1  hold fetch/decode.
- o_uop_vld  out  1  micro-op valid.
- o_uop_reg  out  4  register transferred by this micro-op.
- o_uop_l  out  1  load (1) / store (0), captured L.
- o_uop_offset  out  8  signed two's-complement byte offset from the base Rn.
- o_uop_last  out  1  current micro-op is the final one.
- o_wb_delta  out  8  signed base writeback delta; valid while o_uop_last=1.
- o_done  out  1  one-cycle pulse after the last micro-op is accepted.

Behaviour:
- Reset (i_rst_n low, async): state IDLE; remaining mask 0; all registered outputs 0. o_stall is 0 while in reset.
- States: IDLE, ISSUE.
- IDLE:
  - o_stall = i_is_ldm (combinational).
  - On an edge with i_is_ldm=1 and i_flush=0: capture P, U, L and reglist into the remaining mask.
  - n = popcount(reglist), range 0..16.
  - Start offset: IA (P0 U1) = 0; IB (P1 U1) = +4; DA (P0 U0) = 4-4n; DB (P1 U0) = -4n. All are multiples of WORD_BYTES, computed in 8-bit signed.
  - Captured wb_delta = U ? +4n : -4n.
  - If n>0, go to ISSUE. If n=0: stay in IDLE, pulse o_done next cycle, wb_delta = 0, no micro-op issued.
- ISSUE:
  - o_uop_vld=1.
  - o_uop_reg = index of the lowest set bit of the remaining mask. Registers are issued in ascending order; the lowest register goes to the lowest address.
  - o_uop_last = exactly one bit remaining.
  - o_stall = !(i_uop_rdy & o_uop_last), so decode may advance on the same edge the last micro-op is accepted.
  - On accept (i_uop_rdy=1): clear that bit and add +4 to the offset. If the accepted micro-op was last, return to IDLE and register o_done=1 for one cycle.
  - On a stall (i_uop_rdy=0): all o_uop_* outputs hold stable.
- Latency and throughput:
  - i_is_ldm sampled at edge T gives the first micro-op valid in cycle T+1.
  - With i_uop_rdy held high: one micro-op per cycle; last accepted at edge T+n; o_done high in cycle T+n+1.
- R15 in the list: issued like any other register (o_uop_reg=15); execute handles the PC load.
- Flush:
  - i_flush=1 at any edge forces IDLE and clears the mask, o_uop_vld, and o_done.
  - A flush takes priority over a simultaneous accept or capture.
- In IDLE, i_uop_rdy is ignored.
- i_is_ldm is ignored while in ISSUE. Decode is stalled in ISSUE, so it must hold the same instruction.
- Reset mid-sequence: immediate abort to the reset values. No partial o_done.
- All outputs except o_stall are registered, or decoded from registered state only.

Test Plan:
- LDMIA, reglist 0x000F, P0 U1 L1, rdy=1 -> regs 0,1,2,3; offsets 0,4,8,12; last on R3; wb_delta=+16; o_done at T+5; o_stall high T..T+3, low at T+4.
- STMDB, reglist 0x8001, P1 U0 L0 -> regs 0,15; offsets -8,-4 (0xF8, 0xFC); o_uop_l=0; wb_delta=-8 (0xF8).
- LDMIB, reglist 0x0104 with rdy low for 3 cycles on the first micro-op -> R2 @+4 held stable for 3 cycles; then R8 @+8; o_done is one cycle after the R8 accept.
- LDMDA, reglist 0xFFFF -> 16 micro-ops; offsets -60..0; wb_delta=-64 (0xC0); the last one is R15 @0.
- Empty reglist -> no o_uop_vld; o_stall high only in the sample cycle; o_done pulse next cycle; wb_delta=0.
- Abort cases, reglist 0x00F0: i_flush asserted after the second accept -> IDLE next cycle, no o_done. Repeat with i_rst_n pulsed low mid-sequence -> outputs are 0 asynchronously and no o_done.
